// File: rtl/bkm_data_step_driver.sv
// bkm_data_step_driver: FIFO-buffered stimulus driver for bkm_data_step,
// with an expected-result delay line aligned to the DUT latency.
module bkm_data_step_driver #(
  parameter int W     = 64,
  parameter int LOG2N = 6,
  parameter int LAT   = 1,
  parameter int LOG2D = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_mode,
  input  logic [1:0]       vec_format,
  input  logic [LOG2N-1:0] vec_n,
  input  logic [1:0]       vec_d_x_n,
  input  logic [1:0]       vec_d_y_n,
  input  logic [W-1:0]     vec_X_n,
  input  logic [W-1:0]     vec_Y_n,
  input  logic [W-1:0]     vec_X_np1,
  input  logic [W-1:0]     vec_Y_np1,
  output logic             dut_mode,
  output logic [1:0]       dut_format,
  output logic [LOG2N-1:0] dut_n,
  output logic [1:0]       dut_d_x_n,
  output logic [1:0]       dut_d_y_n,
  output logic [W-1:0]     dut_X_n,
  output logic [W-1:0]     dut_Y_n,
  output logic [W-1:0]     tb_X_np1,
  output logic [W-1:0]     tb_Y_np1,
  output logic             chk_enable,
  output logic             busy,
  output logic             done,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      checked_cnt
);

  typedef struct packed {
    logic             mode;
    logic [1:0]       format;
    logic [LOG2N-1:0] n;
    logic [1:0]       d_x;
    logic [1:0]       d_y;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
  } drv_t;

  typedef struct packed {
    drv_t         d;
    logic [W-1:0] xn1;
    logic [W-1:0] yn1;
  } vec_t;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam int DEPTH = 1 << LOG2D;

  state_t         r_state;
  logic [15:0]    r_num;
  logic [15:0]    r_acc;
  logic [15:0]    r_iss;
  logic [15:0]    r_chk;
  logic [LOG2D:0] r_wp;
  logic [LOG2D:0] r_rp;
  vec_t           r_mem [DEPTH];
  drv_t           r_drv;
  logic [W-1:0]   r_tbx;
  logic [W-1:0]   r_tby;
  logic           r_tbv;

  logic         w_full;
  logic         w_empty;
  logic         w_run;
  logic         w_push;
  logic         w_pop;
  logic         w_last_v;
  logic         w_pipe_busy;
  logic [W-1:0] w_last_x;
  logic [W-1:0] w_last_y;
  vec_t         w_in;
  vec_t         w_head;

  assign w_in = {vec_mode, vec_format, vec_n,
                 vec_d_x_n, vec_d_y_n,
                 vec_X_n, vec_Y_n,
                 vec_X_np1, vec_Y_np1};
  assign w_head  = r_mem[r_rp[LOG2D-1:0]];
  assign w_full  = (r_wp[LOG2D] != r_rp[LOG2D]) &&
                   (r_wp[LOG2D-1:0] == r_rp[LOG2D-1:0]);
  assign w_empty = (r_wp == r_rp);
  assign w_run   = (r_state == S_RUN);

  // Ready ignores a same-cycle pop: a full FIFO always refuses.
  assign vec_ready = enable & w_run & ~w_full & (r_acc < r_num);
  assign w_push    = vec_valid & vec_ready;
  assign w_pop     = enable & w_run & ~w_empty & (r_iss < r_num);

  assign chk_enable  = enable & r_tbv;
  assign busy        = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign issued_cnt  = r_iss;
  assign checked_cnt = r_chk;
  assign tb_X_np1    = r_tbx;
  assign tb_Y_np1    = r_tby;
  assign dut_mode    = r_drv.mode;
  assign dut_format  = r_drv.format;
  assign dut_n       = r_drv.n;
  assign dut_d_x_n   = r_drv.d_x;
  assign dut_d_y_n   = r_drv.d_y;
  assign dut_X_n     = r_drv.x;
  assign dut_Y_n     = r_drv.y;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[LOG2D-1:0]] <= w_in;
  end

  generate
    if (LAT == 0) begin : g_nolat
      assign w_last_v    = w_pop;
      assign w_last_x    = w_head.xn1;
      assign w_last_y    = w_head.yn1;
      assign w_pipe_busy = 1'b0;
    end else begin : g_lat
      logic [LAT-1:0] r_sv;
      logic [W-1:0]   r_sx [LAT];
      logic [W-1:0]   r_sy [LAT];

      always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
          r_sv <= '0;
          for (int i = 0; i < LAT; i++) begin
            r_sx[i] <= '0;
            r_sy[i] <= '0;
          end
        end else if (srst) begin
          r_sv <= '0;
        end else if (enable) begin
          r_sv[0] <= w_pop;
          if (w_pop) begin
            r_sx[0] <= w_head.xn1;
            r_sy[0] <= w_head.yn1;
          end
          for (int i = 1; i < LAT; i++) begin
            r_sv[i] <= r_sv[i-1];
            r_sx[i] <= r_sx[i-1];
            r_sy[i] <= r_sy[i-1];
          end
        end
      end

      assign w_last_v    = r_sv[LAT-1];
      assign w_last_x    = r_sx[LAT-1];
      assign w_last_y    = r_sy[LAT-1];
      assign w_pipe_busy = |r_sv;
    end
  endgenerate

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_acc   <= '0;
      r_iss   <= '0;
      r_chk   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_drv   <= '0;
      r_tbx   <= '0;
      r_tby   <= '0;
      r_tbv   <= 1'b0;
    end else if (srst) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_acc   <= '0;
      r_iss   <= '0;
      r_chk   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_drv   <= '0;
      r_tbx   <= '0;
      r_tby   <= '0;
      r_tbv   <= 1'b0;
    end else if (enable) begin
      if (w_push) begin
        r_wp  <= r_wp + 1'b1;
        r_acc <= r_acc + 16'd1;
      end
      if (w_pop) begin
        r_drv <= w_head.d;
        r_rp  <= r_rp + 1'b1;
        r_iss <= r_iss + 16'd1;
      end
      r_tbv <= w_last_v;
      if (w_last_v) begin
        r_tbx <= w_last_x;
        r_tby <= w_last_y;
      end
      if (r_tbv) r_chk <= r_chk + 16'd1;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_num   <= num_vec;
            r_acc   <= '0;
            r_iss   <= '0;
            r_chk   <= '0;
            r_state <= (num_vec == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop && (r_iss + 16'd1 == r_num))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Last result is counted on the edge the delay line empties.
          if (!w_pipe_busy) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bkm_data_step_driver.sv
// Bench for bkm_data_step_driver: three instances (LAT 0/1/3) share
// stimulus and are compared every cycle against a queue-based model.
module tb_bkm_data_step_driver;

  localparam int W  = 64;
  localparam int LN = 6;
  localparam int LD = 2;

  typedef struct packed {
    logic          mode;
    logic [1:0]    fmt;
    logic [LN-1:0] n;
    logic [1:0]    dx;
    logic [1:0]    dy;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
  } drv_t;

  typedef struct packed {
    drv_t         d;
    logic [W-1:0] xn1;
    logic [W-1:0] yn1;
  } vec_t;

  typedef struct {
    int           ek;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } iss_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst, srst, enable, start;
  logic [15:0]   num_vec;
  logic          vec_valid;
  logic          vec_mode;
  logic [1:0]    vec_format;
  logic [LN-1:0] vec_n;
  logic [1:0]    vec_d_x_n, vec_d_y_n;
  logic [W-1:0]  vec_X_n, vec_Y_n, vec_X_np1, vec_Y_np1;

  logic          rdy [3];
  logic          d_mode [3];
  logic [1:0]    d_fmt [3];
  logic [LN-1:0] d_n [3];
  logic [1:0]    d_dx [3];
  logic [1:0]    d_dy [3];
  logic [W-1:0]  d_x [3];
  logic [W-1:0]  d_y [3];
  logic [W-1:0]  t_x [3];
  logic [W-1:0]  t_y [3];
  logic          ce [3];
  logic          bz [3];
  logic          dn [3];
  logic [15:0]   ic [3];
  logic [15:0]   cc [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bkm_data_step_driver #(
      .W(W), .LOG2N(LN),
      .LAT(g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .LOG2D(LD)
    ) u_dut (
      .clk(clk), .arst(arst), .srst(srst),
      .enable(enable), .start(start),
      .num_vec(num_vec),
      .vec_valid(vec_valid), .vec_ready(rdy[g]),
      .vec_mode(vec_mode), .vec_format(vec_format),
      .vec_n(vec_n),
      .vec_d_x_n(vec_d_x_n), .vec_d_y_n(vec_d_y_n),
      .vec_X_n(vec_X_n), .vec_Y_n(vec_Y_n),
      .vec_X_np1(vec_X_np1), .vec_Y_np1(vec_Y_np1),
      .dut_mode(d_mode[g]), .dut_format(d_fmt[g]),
      .dut_n(d_n[g]),
      .dut_d_x_n(d_dx[g]), .dut_d_y_n(d_dy[g]),
      .dut_X_n(d_x[g]), .dut_Y_n(d_y[g]),
      .tb_X_np1(t_x[g]), .tb_Y_np1(t_y[g]),
      .chk_enable(ce[g]), .busy(bz[g]), .done(dn[g]),
      .issued_cnt(ic[g]), .checked_cnt(cc[g])
    );
  end

  vec_t         src [$];
  vec_t         fq [$];
  iss_t         il [$];
  drv_t         m_drv;
  int           m_num, m_acc, m_iss, m_k;
  bit           arm [3];
  bit           dne [3];
  int           m_chk [3];
  logic [W-1:0] m_tx [3];
  logic [W-1:0] m_ty [3];
  bit           e_rdy, e_pop, hold;
  int           en_pct, val_pct;
  int           n_as, n_fail;

  function automatic int lat_of(int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_as++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.d.mode = 1'($urandom);
    v.d.fmt  = 2'($urandom);
    v.d.n    = LN'($urandom);
    v.d.dx   = 2'($urandom);
    v.d.dy   = 2'($urandom);
    v.d.x    = {$urandom, $urandom};
    v.d.y    = {$urandom, $urandom};
    v.xn1    = {$urandom, $urandom};
    v.yn1    = {$urandom, $urandom};
    return v;
  endfunction

  function automatic vec_t cur_vec();
    vec_t v;
    v.d.mode = vec_mode;
    v.d.fmt  = vec_format;
    v.d.n    = vec_n;
    v.d.dx   = vec_d_x_n;
    v.d.dy   = vec_d_y_n;
    v.d.x    = vec_X_n;
    v.d.y    = vec_Y_n;
    v.xn1    = vec_X_np1;
    v.yn1    = vec_Y_np1;
    return v;
  endfunction

  function automatic bit vis(int g, int k);
    if (!arm[g] || m_chk[g] >= il.size()) return 1'b0;
    return (il[m_chk[g]].ek + lat_of(g) == k);
  endfunction

  task automatic model_reset();
    fq.delete();
    il.delete();
    m_drv = '0;
    m_num = 0; m_acc = 0; m_iss = 0; m_k = 0;
    for (int g = 0; g < 3; g++) begin
      arm[g] = 1'b0; dne[g] = 1'b0; m_chk[g] = 0;
      m_tx[g] = '0; m_ty[g] = '0;
    end
  endtask

  task automatic check_all();
    bit run;
    bit v;
    logic [W-1:0] ex, ey;
    run   = arm[0] && (m_iss < m_num);
    e_rdy = enable && run && (fq.size() < 4) && (m_acc < m_num);
    e_pop = enable && run && (fq.size() > 0) && (m_iss < m_num);
    for (int g = 0; g < 3; g++) begin
      string s;
      s  = $sformatf("L%0d", lat_of(g));
      v  = vis(g, m_k);
      ex = v ? il[m_chk[g]].x : m_tx[g];
      ey = v ? il[m_chk[g]].y : m_ty[g];
      chk({s, " vec_ready"}, rdy[g], e_rdy);
      chk({s, " dut_bus"},
          {d_mode[g], d_fmt[g], d_n[g], d_dx[g], d_dy[g],
           d_x[g], d_y[g]}, m_drv);
      chk({s, " chk_enable"}, ce[g], v && enable);
      chk({s, " tb_X_np1"}, t_x[g], ex);
      chk({s, " tb_Y_np1"}, t_y[g], ey);
      chk({s, " busy"}, bz[g], arm[g]);
      chk({s, " done"}, dn[g], dne[g]);
      chk({s, " issued_cnt"}, ic[g], 16'(m_iss));
      chk({s, " checked_cnt"}, cc[g], 16'(m_chk[g]));
    end
  endtask

  task automatic model_edge();
    bit   pre [3];
    bit   any;
    int   k0;
    vec_t v;
    iss_t it;
    if (srst) begin
      model_reset();
      return;
    end
    if (!enable) return;
    k0  = m_k;
    m_k = m_k + 1;
    any = 1'b0;
    for (int g = 0; g < 3; g++) begin
      pre[g] = arm[g];
      any    = any | arm[g];
      if (vis(g, k0)) begin
        m_tx[g] = il[m_chk[g]].x;
        m_ty[g] = il[m_chk[g]].y;
        m_chk[g]++;
      end
    end
    if (e_pop) begin
      v = fq.pop_front();
      m_drv = v.d;
      m_iss++;
      it.ek = m_k; it.x = v.xn1; it.y = v.yn1;
      il.push_back(it);
    end
    if (vec_valid && e_rdy) begin
      fq.push_back(cur_vec());
      m_acc++;
    end
    for (int g = 0; g < 3; g++) begin
      if (pre[g] && m_iss == m_num && m_chk[g] == m_num) begin
        arm[g] = 1'b0;
        dne[g] = 1'b1;
      end
    end
    if (start && !any) begin
      m_num = int'(num_vec);
      m_acc = 0; m_iss = 0;
      il.delete();
      for (int g = 0; g < 3; g++) begin
        m_chk[g] = 0;
        arm[g] = (m_num != 0);
        dne[g] = (m_num == 0);
      end
    end
  endtask

  task automatic cycle();
    vec_t v;
    enable = ($urandom_range(99) < en_pct);
    if (!hold) begin
      if (src.size() > 0 && $urandom_range(99) < val_pct) begin
        v = src[0];
        vec_valid  = 1'b1;
        vec_mode   = v.d.mode;
        vec_format = v.d.fmt;
        vec_n      = v.d.n;
        vec_d_x_n  = v.d.dx;
        vec_d_y_n  = v.d.dy;
        vec_X_n    = v.d.x;
        vec_Y_n    = v.d.y;
        vec_X_np1  = v.xn1;
        vec_Y_np1  = v.yn1;
      end else begin
        vec_valid = 1'b0;
      end
    end
    #1;
    check_all();
    model_edge();
    if (vec_valid) begin
      if (e_rdy) begin
        void'(src.pop_front());
        hold = 1'b0;
      end else begin
        hold = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_run(int n);
    int sv;
    sv = en_pct;
    en_pct  = 100;
    num_vec = 16'(n);
    start   = 1'b1;
    cycle();
    start  = 1'b0;
    en_pct = sv;
  endtask

  task automatic wait_done(int n, int lim);
    int c;
    c = 0;
    while ((arm[0] || arm[1] || arm[2]) && c < lim) begin
      cycle();
      c++;
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("L%0d final_done", lat_of(g)), dn[g], 1'b1);
      chk($sformatf("L%0d final_iss", lat_of(g)), ic[g], 16'(n));
      chk($sformatf("L%0d final_chk", lat_of(g)), cc[g], 16'(n));
    end
  endtask

  task automatic run_until_iss(int n, int lim);
    int c;
    c = 0;
    while (m_iss < n && c < lim) begin
      cycle();
      c++;
    end
    chk("reach_issue", ic[0], 16'(n));
  endtask

  task automatic do_arst();
    arst      = 1'b0;
    vec_valid = 1'b0;
    hold      = 1'b0;
    src.delete();
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
  endtask

  initial begin
    vec_t v;
    n_as = 0; n_fail = 0;
    hold = 1'b0; en_pct = 100; val_pct = 100;
    arst = 1'b0; srst = 1'b0; enable = 1'b0; start = 1'b0;
    num_vec = '0; vec_valid = 1'b0;
    vec_mode = '0; vec_format = '0; vec_n = '0;
    vec_d_x_n = '0; vec_d_y_n = '0;
    vec_X_n = '0; vec_Y_n = '0; vec_X_np1 = '0; vec_Y_np1 = '0;
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    arst = 1'b1;

    // back-to-back run of three known vectors
    for (int i = 1; i <= 3; i++) begin
      v = rand_vec();
      v.d.x = 64'(i);
      v.xn1 = 64'(10 * i);
      src.push_back(v);
    end
    start_run(3);
    wait_done(3, 100);

    // eight vectors with valid held high
    for (int i = 0; i < 8; i++) src.push_back(rand_vec());
    start_run(8);
    wait_done(8, 100);

    // enable gap between the two issues
    for (int i = 0; i < 2; i++) src.push_back(rand_vec());
    start_run(2);
    run_until_iss(1, 20);
    en_pct = 0;
    cycle();
    cycle();
    en_pct = 100;
    wait_done(2, 50);

    // empty run
    start_run(0);
    wait_done(0, 5);

    // re-arm from DONE with a single vector
    v = rand_vec();
    v.xn1 = 64'h7;
    src.push_back(v);
    start_run(1);
    wait_done(1, 50);
    for (int g = 0; g < 3; g++)
      chk($sformatf("L%0d tb_X_np1_7", lat_of(g)), t_x[g], 64'h7);

    // async reset mid-run, with an ignored start while busy
    for (int i = 0; i < 5; i++) src.push_back(rand_vec());
    start_run(5);
    num_vec = 16'd9;
    start   = 1'b1;
    cycle();
    start = 1'b0;
    run_until_iss(2, 30);
    do_arst();
    for (int i = 0; i < 8; i++) cycle();

    // sync reset mid-run
    for (int i = 0; i < 4; i++) src.push_back(rand_vec());
    start_run(4);
    run_until_iss(1, 30);
    srst = 1'b1;
    vec_valid = 1'b0;
    hold = 1'b0;
    src.delete();
    cycle();
    srst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // randomized runs with random enable and valid gaps
    en_pct  = 75;
    val_pct = 60;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) src.push_back(rand_vec());
      start_run(n);
      wait_done(n, 400);
      for (int i = 0; i < 3; i++) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_as, n_fail);
    $finish;
  end

endmodule
